// File: rtl/bitwise_logic_pipe_if.sv
// bitwise_logic_pipe_if
//   Handshake bundle for bitwise_logic_pipe.
//   master : upstream/downstream side. Drives in_valid, a, b, op and out_ready.
//   slave  : the logic unit. Drives in_ready, out_valid, y and zero.
//   WIDTH  : operand/result width; must match the attached block.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Pipelined WIDTH-bit logic unit with eight selectable operations.
//   The result and its zero flag are computed at the input and captured into
//   stage 0. They then ripple through STAGES register stages with full
//   valid/ready backpressure, in strict FIFO order.
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   bus      : slave side of bitwise_logic_pipe_if. It carries:
//              in_valid/in_ready/a/b/op on the input side and
//              out_valid/out_ready/y/zero on the output side.
//   op_count : number of accepted transactions, wrapping modulo 2^CNT_W
module bitwise_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  bitwise_logic_pipe_if.slave bus,
  output logic [CNT_W-1:0]    op_count
);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] opa,
    input logic [WIDTH-1:0] opb,
    input logic [2:0]       sel
  );
    logic [WIDTH-1:0] res;
    case (sel)
      3'b000:  res = ~opa;
      3'b001:  res = opa & opb;
      3'b010:  res = opa | opb;
      3'b011:  res = opa ^ opb;
      3'b100:  res = ~(opa & opb);
      3'b101:  res = ~(opa | opb);
      3'b110:  res = ~(opa ^ opb);
      3'b111:  res = opa;
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0]  res_s;
  logic              res_zero_s;
  logic              acc_s;
  logic              hole_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] zero_r;
  logic [WIDTH-1:0]  y_r [STAGES];

  assign res_s      = logic_op(bus.a, bus.b, bus.op);
  assign res_zero_s = (res_s == {WIDTH{1'b0}});

  // Advance chain. Stage k may move when any stage at or beyond k is empty,
  // or when the output is taking a word. This is the flattened form of
  // "stage k empty, or stage k+1 advances".
  always_comb begin
    hole_s = 1'b0;
    adv_s  = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole_s   = hole_s | ~vld_r[k];
      adv_s[k] = hole_s | bus.out_ready;
    end
  end

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign bus.in_ready = adv_s[0];
  assign acc_s        = bus.in_valid & adv_s[0];

  // Pipeline registers. Stage 0 captures a fresh result. Later stages copy
  // their predecessor. Data only moves with a valid word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r  <= {STAGES{1'b0}};
      zero_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        y_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      if (adv_s[0]) begin
        vld_r[0] <= bus.in_valid;
        if (bus.in_valid) begin
          y_r[0]    <= res_s;
          zero_r[0] <= res_zero_s;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv_s[k]) begin
          vld_r[k] <= vld_r[k-1];
          if (vld_r[k-1]) begin
            y_r[k]    <= y_r[k-1];
            zero_r[k] <= zero_r[k-1];
          end
        end
      end
    end
  end

  // Accepted-transaction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= {CNT_W{1'b0}};
    end else if (acc_s) begin
      op_count <= op_count + CNT_W'(1);
    end else begin
      op_count <= op_count;
    end
  end

  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.y         = y_r[STAGES-1];
  assign bus.zero      = zero_r[STAGES-1];

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
Parametrised, pipelined bitwise logic unit that generalises the single-bit inverter to WIDTH-bit operands and eight selectable logic operations. Operands and op enter through a valid/ready handshake. The result passes through STAGES register stages and leaves through a valid/ready handshake with full backpressure. It sits beside the ALU datapath as the standalone logic-op block and its verification vehicle.

Parameters:
WIDTH, 32, operand and result width in bits (legal 1..64)
STAGES, 2, number of pipeline register stages (legal 1..4)
CNT_W, 16, width of accepted-transaction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents a, b, op
in_ready  output  1  block accepts this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored by ops 000 and 111)
op  input  3  operation select
out_valid  output  1  y/zero valid
out_ready  input  1  downstream accepts this cycle
y  output  WIDTH  result
zero  output  1  1 when y == 0
op_count  output  CNT_W  number of accepted transactions, wraps modulo 2^CNT_W

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, named rst. Clock is named clk.
- Op encoding:
  - 000 y=~a
  - 001 a&b
  - 010 a|b
  - 011 a^b
  - 100 ~(a&b)
  - 101 ~(a|b)
  - 110 ~(a^b)
  - 111 y=a (pass)
- The result is computed combinationally at the input and captured into stage 0. Stages 1..STAGES-1 only carry {valid, y, zero}. zero is computed before the stage-0 capture and travels with the data.
- Accept: transfer when in_valid && in_ready on a rising edge. Emit: transfer when out_valid && out_ready.
- Stage k advances when stage k is empty, or when stage k+1 advances or is empty. The last stage advances on an output transfer or when it is empty.
- in_ready = !v[0] || stage 0 advancing. in_ready must not depend on in_valid. There are no combinational loops; in_ready may depend combinationally on out_ready.
- Latency: with out_ready held high, a word accepted at edge N appears with out_valid=1 after edge N+STAGES-1. It transfers at edge N+STAGES.
- Throughput: one transaction per cycle when out_ready=1 continuously. No bubbles are inserted.
- Stall (out_ready=0):
  - Held stages keep y and zero stable and out_valid asserted.
  - Empty stages keep filling.
  - Once all STAGES stages are valid, in_ready=0.
  - Data is never dropped or duplicated.
- Ordering: strict FIFO order.
- op_count increments by 1 on each input transfer. It wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous, at any time, including mid-stall):
  - All valids clear immediately, so out_valid=0.
  - y=0, zero=0, op_count=0.
  - In-flight data is discarded.
  - in_ready=1 in the first cycle after rst deasserts.
- When in_valid=0 or out_valid=0, changes on a, b, op or out_ready have no effect on state.
- Undriven or X op is a bench error. Reserved codes do not exist; all 8 codes are defined.

Test Plan:
- Reset during activity: WIDTH=8, STAGES=2. Assert rst while out_valid=1 -> out_valid=0, y=0x00, zero=0, op_count=0 immediately; in_ready=1 after release.
- All ops, back-to-back: a=0xF0, b=0xCC, op 000..111 on consecutive cycles, out_ready=1 -> y sequence 0x0F, 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0xF0. First result valid 1 cycle after first accept (STAGES=2), then one per cycle. op_count=8.
- Zero flag: a=0xAA, b=0xAA, op=011 -> y=0x00, zero=1. op=101 with a=0xFF -> y=0x00, zero=1. op=000 with a=0x00 -> y=0xFF, zero=0.
- Backpressure: out_ready=0, push 3 words (0x01, 0x02, 0x03, op=111) -> 2 accepted, then in_ready=0. y holds 0x01 stable. Raise out_ready -> outputs 0x01, 0x02, 0x03 in order, none lost.
- Counter wrap: CNT_W=4, 17 accepted transactions -> op_count=1.
- Random soak, WIDTH=32, STAGES=1 and 4: random in_valid and out_ready, compare against a reference model queue -> zero mismatches, order preserved.
